mem_stage_ld: RTL and testbench
===============================

Name: mem_stage_ld

Overview:
- Parametrised successor of the in-order MEM pipeline stage. Sits between EX and WB and uses the valid/allowin pipeline handshake.
- Adds a variable-latency data SRAM response (data_ok) with wait/hold buffering.
- Adds byte/halfword/word load alignment with sign or zero extension.
- Adds pipeline flush with discard of stale in-flight responses, plus a forwarding port to ID.

Parameters:
- DATA_W, 32, data/result width; legal values 32 or 64.
- DEST_W, 5, register-file index width.
- PC_W, 32, PC width.
- DISC_W, 2, width of the stale-response discard counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset. One clock; synchronous, active-high.
- ws_allowin  in  1  WB can accept.
- ms_allowin  out  1  MEM can accept.
- es_to_ms_valid  in  1  EX has an instruction.
- es_to_ms_bus  in  6+DEST_W+DATA_W+PC_W  {req_issued, ld_type[2:0], res_from_mem, gr_we, dest, alu_result, pc}, MSB first.
- ms_to_ws_valid  out  1  result valid to WB.
- ms_to_ws_bus  out  1+DEST_W+DATA_W+PC_W  {gr_we, dest, final_result, pc}.
- data_sram_data_ok  in  1  one-cycle pulse; read data or write ack returned, in order.
- data_sram_rdata  in  DATA_W  read data, valid with data_ok.
- ms_flush  in  1  kill the instruction currently held in MEM.
- ms_fwd_valid  out  1  MEM holds a valid GPR writer.
- ms_fwd_dest  out  DEST_W  its destination.
- ms_fwd_data  out  DATA_W  its result.
- ms_fwd_pending  out  1  the result is load data not yet returned; ID must stall.
- in_ms_valid  out  1  raw ms_valid, for hazard logic.

Behaviour:
- Reset: ms_valid=0, state=IDLE, disc_cnt=0, hold register cleared. Consequently ms_to_ws_valid=0, ms_allowin=1, all fwd outputs 0.
- Capture: when es_to_ms_valid && ms_allowin, latch the bus. ms_valid<=es_to_ms_valid whenever ms_allowin. ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- State machine (per held instruction):
  - IDLE: no request to wait for.
  - WAIT: req_issued=1 and response not yet seen.
  - HOLD: response captured into hold_data, WB has not yet taken the instruction.
- Entry state on capture: WAIT if req_issued else IDLE.
- WAIT transitions: on an accepted (non-discarded) data_ok, go to HOLD and latch rdata into hold_data.
- HOLD / IDLE: leave when WB takes the instruction (ms_to_ws_valid && ws_allowin). Next state is IDLE or WAIT according to the newly captured entry, or IDLE with ms_valid=0.
- Ready: ms_ready_go = (state!=WAIT) || accepted data_ok this cycle.
  - Zero-bubble: the data_ok cycle may forward live rdata directly to WB.
  - Minimum MEM latency is 1 cycle; a load holds MEM until data_ok.
- Alignment, with off = alu_result[log2(DATA_W/8)-1:0]:
  - LD_B=0: byte at off, sign-extended. LD_BU=3: same, zero-extended.
  - LD_H=1: halfword at off & ~1, sign-extended. LD_HU=4: same, zero-extended.
  - LD_W=2: word at off & ~3; sign-extended when DATA_W=64.
  - LD_D=5: full DATA_W; legal only for DATA_W=64.
  - Codes 6/7: treated as LD_W.
- Result: final_result = res_from_mem ? aligned(rdata-or-hold_data) : alu_result.
- Stores: req_issued=1, res_from_mem=0. They also wait for data_ok (write ack); rdata is ignored.
- Flush: ms_flush forces ms_valid<=0 and state<=IDLE next cycle, overriding capture in that cycle.
  - If the flush happens in WAIT and data_ok is not present that cycle, disc_cnt increments.
- Discard: any data_ok while disc_cnt!=0 is consumed silently and decrements disc_cnt. It never satisfies the current WAIT.
  - A simultaneous new flush-increment and decrement nets to no change.
- Saturation: disc_cnt must not exceed 2^DISC_W-1. It is an assertion error if it would.
- Stray response: data_ok in IDLE/HOLD with disc_cnt=0 is a protocol error, flagged by assertion and ignored.
- Reset mid-WAIT: all state is cleared. The memory side is also in reset, so no discard accounting is needed.

Optional Feature:
- Macro: MS_FWD_EN.
- Defined: the fwd outputs are driven.
  - ms_fwd_valid = ms_valid && gr_we.
  - ms_fwd_pending = res_from_mem && (state==WAIT) && no accepted data_ok this cycle.
  - ms_fwd_data = final_result.
- Undefined: all fwd outputs are tied to 0. ID falls back to stalling on in_ms_valid.

Decomposition:
- Shared package (pipeline defs): LD_B..LD_D codes, MS_IDLE/WAIT/HOLD state encoding, bus-width localparams ES_TO_MS_W and MS_TO_WS_W.
- Sub-module load_align:
  - Combinational.
  - Inputs: DATA_W data, off, ld_type.
  - Output: the extended result.
  - Reusable later by an atomic/LL path.

Test Plan:
- ALU op pass-through: req_issued=0, alu_result=0x1234_5678, ws_allowin=1. Required: ms_to_ws_valid one cycle after capture, final_result=0x1234_5678.
- LD_B sign-extension: rdata=0x80FF_7F01, off=3, data_ok 3 cycles after capture. Required: ms_to_ws_valid asserts on the data_ok cycle, result 0xFFFF_FF80. Repeat with LD_BU: required 0x0000_0080.
- HOLD buffering: LD_HU, off=2, rdata=0xBEEF_0000 arrives while ws_allowin=0, rdata changes next cycle. Required: when ws_allowin rises 2 cycles later, result 0x0000_BEEF; ms_allowin=0 throughout.
- Flush in WAIT: flush a load in WAIT. Required: disc_cnt=1. Then capture a new load. Required: its first data_ok (0xDEAD_DEAD) is dropped, its second data_ok (0x0000_0042) delivers 0x42.
- Simultaneous flush and data_ok in WAIT. Required: disc_cnt stays 0, no ms_to_ws_valid.
- MS_FWD_EN: load in WAIT with dest=7. Required: fwd_valid=1, fwd_dest=7, fwd_pending=1; fwd_pending=0 in the data_ok cycle. Without the macro: all fwd outputs 0.

Source files
------------

// File: rtl/mem_stage_ld_pkg.sv
// Shared pipeline definitions for the MEM load stage: load-type codes,
// per-instruction state encoding and EX->MEM / MEM->WB bus widths.
package mem_stage_ld_pkg;

    localparam logic [2:0] LD_B  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_W  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;
    localparam logic [2:0] LD_D  = 3'd5;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_HOLD = 2'd2
    } ms_state_e;

    // {req_issued, ld_type[2:0], res_from_mem, gr_we, dest, alu_result, pc}
    function automatic int es_to_ms_w(input int dest_w, input int data_w, input int pc_w);
        return 6 + dest_w + data_w + pc_w;
    endfunction

    // {gr_we, dest, final_result, pc}
    function automatic int ms_to_ws_w(input int dest_w, input int data_w, input int pc_w);
        return 1 + dest_w + data_w + pc_w;
    endfunction

    localparam int ES_TO_MS_W = 6 + 5 + 32 + 32;
    localparam int MS_TO_WS_W = 1 + 5 + 32 + 32;

endpackage

// File: rtl/mem_stage_ld_load_align.sv
// Combinational load alignment: selects byte/halfword/word/dword at the
// given byte offset and sign- or zero-extends it to DATA_W.
module mem_stage_ld_load_align
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        ld_type,
    output logic [DATA_W-1:0] result
);

    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [DATA_W-1:0] sh_b;
    logic [DATA_W-1:0] sh_h;
    logic [DATA_W-1:0] sh_w;

    always_comb begin
        off_h = off & ~OFF_W'(1);
        off_w = off & ~OFF_W'(3);
        sh_b  = data >> {off, 3'b000};
        sh_h  = data >> {off_h, 3'b000};
        sh_w  = data >> {off_w, 3'b000};
        case (ld_type)
            LD_B:    result = DATA_W'($signed(sh_b[7:0]));
            LD_BU:   result = DATA_W'(sh_b[7:0]);
            LD_H:    result = DATA_W'($signed(sh_h[15:0]));
            LD_HU:   result = DATA_W'(sh_h[15:0]);
            LD_D:    result = data;
            default: result = DATA_W'($signed(sh_w[31:0]));  // LD_W and codes 6/7
        endcase
    end

endmodule

// File: rtl/mem_stage_ld.sv
// In-order MEM stage with variable-latency data SRAM response, hold buffer,
// load alignment, flush with stale-response discard. MS_FWD_EN drives the ID forwarding port.
module mem_stage_ld
    import mem_stage_ld_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int PC_W   = 32,
    parameter int DISC_W = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         ws_allowin,
    output logic                                         ms_allowin,
    input  logic                                         es_to_ms_valid,
    input  logic [es_to_ms_w(DEST_W, DATA_W, PC_W)-1:0]  es_to_ms_bus,
    output logic                                         ms_to_ws_valid,
    output logic [ms_to_ws_w(DEST_W, DATA_W, PC_W)-1:0]  ms_to_ws_bus,
    input  logic                                         data_sram_data_ok,
    input  logic [DATA_W-1:0]                            data_sram_rdata,
    input  logic                                         ms_flush,
    output logic                                         ms_fwd_valid,
    output logic [DEST_W-1:0]                            ms_fwd_dest,
    output logic [DATA_W-1:0]                            ms_fwd_data,
    output logic                                         ms_fwd_pending,
    output logic                                         in_ms_valid
);

    localparam int ES_W  = es_to_ms_w(DEST_W, DATA_W, PC_W);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              ms_valid;
    logic [ES_W-1:0]   bus_r;
    ms_state_e         state;
    logic [DISC_W-1:0] disc_cnt;
    logic [DATA_W-1:0] hold_data;

    logic              req_issued, res_from_mem, gr_we;
    logic [2:0]        ld_type;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] alu_result, mem_src, aligned, final_result;
    logic [PC_W-1:0]   pc;

    assign {req_issued, ld_type, res_from_mem, gr_we, dest, alu_result, pc} = bus_r;

    // A response is for the held instruction only when no stale responses are owed.
    logic discard, acc_ok, ms_ready_go, disc_inc, disc_dec;
    assign discard     = data_sram_data_ok && (disc_cnt != '0);
    assign acc_ok      = data_sram_data_ok && (disc_cnt == '0) && (state == MS_WAIT);
    assign ms_ready_go = (state != MS_WAIT) || acc_ok;
    assign disc_inc    = ms_flush && (state == MS_WAIT) && !acc_ok;
    assign disc_dec    = discard;

    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign in_ms_valid    = ms_valid;

    assign mem_src = (state == MS_HOLD) ? hold_data : data_sram_rdata;

    mem_stage_ld_load_align #(.DATA_W(DATA_W)) u_align (
        .data    (mem_src),
        .off     (alu_result[OFF_W-1:0]),
        .ld_type (ld_type),
        .result  (aligned)
    );

    assign final_result = res_from_mem ? aligned : alu_result;
    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid  <= 1'b0;
            bus_r     <= '0;
            state     <= MS_IDLE;
            disc_cnt  <= '0;
            hold_data <= '0;
        end else begin
            if (disc_inc && !disc_dec)
                disc_cnt <= disc_cnt + 1'b1;
            else if (disc_dec && !disc_inc)
                disc_cnt <= disc_cnt - 1'b1;

            if (ms_flush) begin
                ms_valid <= 1'b0;
                state    <= MS_IDLE;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
                state    <= MS_IDLE;
                if (es_to_ms_valid) begin
                    bus_r <= es_to_ms_bus;
                    if (es_to_ms_bus[ES_W-1])
                        state <= MS_WAIT;
                end
            end else if (acc_ok) begin
                state     <= MS_HOLD;
                hold_data <= data_sram_rdata;
            end
        end
    end

    a_disc_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(disc_inc && !disc_dec && (&disc_cnt)));

    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (reset)
        !(data_sram_data_ok && (disc_cnt == '0) && (state != MS_WAIT)));

`ifdef MS_FWD_EN
    assign ms_fwd_valid   = ms_valid && gr_we;
    assign ms_fwd_dest    = dest;
    assign ms_fwd_data    = final_result;
    assign ms_fwd_pending = res_from_mem && (state == MS_WAIT) && !acc_ok;
`else
    assign ms_fwd_valid   = 1'b0;
    assign ms_fwd_dest    = '0;
    assign ms_fwd_data    = '0;
    assign ms_fwd_pending = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ld.sv
// Directed bench for mem_stage_ld: pass-through, load alignment, hold buffer,
// flush/discard and forwarding port (checked for whichever MS_FWD_EN build is compiled).
module tb_mem_stage_ld;
    import mem_stage_ld_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int PC_W   = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  ws_allowin;
    logic                  ms_allowin;
    logic                  es_to_ms_valid;
    logic [ES_TO_MS_W-1:0] es_to_ms_bus;
    logic                  ms_to_ws_valid;
    logic [MS_TO_WS_W-1:0] ms_to_ws_bus;
    logic                  data_sram_data_ok;
    logic [DATA_W-1:0]     data_sram_rdata;
    logic                  ms_flush;
    logic                  ms_fwd_valid;
    logic [DEST_W-1:0]     ms_fwd_dest;
    logic [DATA_W-1:0]     ms_fwd_data;
    logic                  ms_fwd_pending;
    logic                  in_ms_valid;

    int checks = 0;
    int errors = 0;

    mem_stage_ld dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_flush          (ms_flush),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_fwd_dest       (ms_fwd_dest),
        .ms_fwd_data       (ms_fwd_data),
        .ms_fwd_pending    (ms_fwd_pending),
        .in_ms_valid       (in_ms_valid)
    );

    always #5 clk = ~clk;

    // ---- driver helpers ----
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ES_TO_MS_W-1:0] make_bus(input logic req, input logic [2:0] ld,
                                                       input logic rfm, input logic we,
                                                       input logic [4:0] dst, input logic [31:0] alu,
                                                       input logic [31:0] pc);
        return {req, ld, rfm, we, dst, alu, pc};
    endfunction

    function automatic logic [31:0] res_of(input logic [MS_TO_WS_W-1:0] b);
        return b[PC_W +: DATA_W];
    endfunction

    task automatic drive_quiet();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        ms_flush          = 1'b0;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_bus = '0; data_sram_rdata = '0;
        drive_quiet();
        repeat (3) cycle();
        reset = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL reset_in_ms_valid got=%b exp=0", in_ms_valid); end
        checks++; if ({ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_pending} !== '0) begin errors++; $display("FAIL reset_fwd got=%b/%0d/%h/%b exp=0", ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_pending); end
        checks++; if (dut.disc_cnt !== 2'd0) begin errors++; $display("FAIL reset_disc got=%0d exp=0", dut.disc_cnt); end
    endtask

    task automatic test_alu_pass();
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b0, LD_W, 1'b0, 1'b1, 5'd3, 32'h1234_5678, 32'h0000_1000);
        #1;
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin got=%b exp=1", ms_allowin); end
        cycle();
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got=%b exp=1", ms_to_ws_valid); end
        checks++; if (ms_to_ws_bus !== {1'b1, 5'd3, 32'h1234_5678, 32'h0000_1000}) begin errors++; $display("FAIL alu_bus got=%h exp=%h", ms_to_ws_bus, {1'b1, 5'd3, 32'h1234_5678, 32'h0000_1000}); end
        cycle();
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b exp=0", in_ms_valid); end
    endtask

    task automatic test_load_byte(input logic [2:0] ld, input logic [31:0] exp);
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b1, ld, 1'b1, 1'b1, 5'd7, 32'h0000_2003, 32'h0000_1004);
        cycle();
        es_to_ms_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            #1;
            checks++; if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b0) begin errors++; $display("FAIL ld_wait%0d got valid=%b allowin=%b exp 0/0", i, ms_to_ws_valid, ms_allowin); end
`ifdef MS_FWD_EN
            checks++; if ({ms_fwd_valid, ms_fwd_dest, ms_fwd_pending} !== {1'b1, 5'd7, 1'b1}) begin errors++; $display("FAIL fwd_wait got=%b/%0d/%b exp=1/7/1", ms_fwd_valid, ms_fwd_dest, ms_fwd_pending); end
`else
            checks++; if ({ms_fwd_valid, ms_fwd_dest, ms_fwd_pending} !== '0) begin errors++; $display("FAIL fwd_off got=%b/%0d/%b exp=0", ms_fwd_valid, ms_fwd_dest, ms_fwd_pending); end
`endif
            cycle();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_7F01;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL ld_ok_valid got=%b exp=1", ms_to_ws_valid); end
        checks++; if (res_of(ms_to_ws_bus) !== exp) begin errors++; $display("FAIL ld_result type=%0d got=%h exp=%h", ld, res_of(ms_to_ws_bus), exp); end
`ifdef MS_FWD_EN
        checks++; if (ms_fwd_pending !== 1'b0 || ms_fwd_data !== exp) begin errors++; $display("FAIL fwd_ok got pend=%b data=%h exp 0/%h", ms_fwd_pending, ms_fwd_data, exp); end
`else
        checks++; if (ms_fwd_data !== '0) begin errors++; $display("FAIL fwd_off_data got=%h exp=0", ms_fwd_data); end
`endif
        cycle();
        data_sram_data_ok = 1'b0;
        #1;
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL ld_drain got=%b exp=0", in_ms_valid); end
    endtask

    task automatic test_hold();
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b1, LD_HU, 1'b1, 1'b1, 5'd9, 32'h0000_3002, 32'h0000_1008);
        cycle();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_0000;
        #1;
        checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL hold_allowin0 got=%b exp=0", ms_allowin); end
        cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h1234_5678;
        #1;
        checks++; if (dut.state !== MS_HOLD) begin errors++; $display("FAIL hold_state got=%0d exp=%0d", dut.state, MS_HOLD); end
        checks++; if (ms_allowin !== 1'b0 || ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL hold_hs got allowin=%b valid=%b exp 0/1", ms_allowin, ms_to_ws_valid); end
        cycle();
        ws_allowin = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || res_of(ms_to_ws_bus) !== 32'h0000_BEEF) begin errors++; $display("FAIL hold_result got valid=%b res=%h exp 1/0000beef", ms_to_ws_valid, res_of(ms_to_ws_bus)); end
        checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL hold_release got=%b exp=1", ms_allowin); end
        cycle();
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got=%b exp=0", in_ms_valid); end
    endtask

    task automatic test_flush_wait();
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b1, LD_W, 1'b1, 1'b1, 5'd4, 32'h0000_4000, 32'h0000_100C);
        cycle();
        es_to_ms_valid = 1'b0;
        ms_flush = 1'b1;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", ms_to_ws_valid); end
        cycle();
        ms_flush = 1'b0;
        #1;
        checks++; if (dut.disc_cnt !== 2'd1) begin errors++; $display("FAIL flush_disc got=%0d exp=1", dut.disc_cnt); end
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL flush_killed got=%b exp=0", in_ms_valid); end
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b1, LD_W, 1'b1, 1'b1, 5'd5, 32'h0000_5000, 32'h0000_1010);
        cycle();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hDEAD_DEAD;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL stale_dropped got=%b exp=0", ms_to_ws_valid); end
        cycle();
        data_sram_rdata = 32'h0000_0042;
        #1;
        checks++; if (dut.disc_cnt !== 2'd0) begin errors++; $display("FAIL stale_dec got=%0d exp=0", dut.disc_cnt); end
        checks++; if (ms_to_ws_valid !== 1'b1 || res_of(ms_to_ws_bus) !== 32'h0000_0042) begin errors++; $display("FAIL fresh_result got valid=%b res=%h exp 1/00000042", ms_to_ws_valid, res_of(ms_to_ws_bus)); end
        cycle();
        data_sram_data_ok = 1'b0;
    endtask

    task automatic test_flush_with_ok();
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b1, LD_W, 1'b1, 1'b1, 5'd6, 32'h0000_6000, 32'h0000_1014);
        cycle();
        es_to_ms_valid = 1'b0;
        ms_flush = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h1111_1111;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL flushok_valid got=%b exp=0", ms_to_ws_valid); end
        cycle();
        ms_flush = 1'b0;
        data_sram_data_ok = 1'b0;
        #1;
        checks++; if (dut.disc_cnt !== 2'd0) begin errors++; $display("FAIL flushok_disc got=%0d exp=0", dut.disc_cnt); end
        checks++; if (in_ms_valid !== 1'b0 || dut.state !== MS_IDLE) begin errors++; $display("FAIL flushok_state got valid=%b state=%0d exp 0/0", in_ms_valid, dut.state); end
    endtask

    task automatic test_back_to_back();
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = make_bus(1'b0, LD_W, 1'b0, 1'b1, 5'd1, 32'hAAAA_0001, 32'h0000_2000);
        cycle();
        es_to_ms_bus = make_bus(1'b1, LD_W, 1'b0, 1'b0, 5'd2, 32'hA5A5_0004, 32'h0000_2004);
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_allowin !== 1'b1 || res_of(ms_to_ws_bus) !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_first got valid=%b allowin=%b res=%h exp 1/1/aaaa0001", ms_to_ws_valid, ms_allowin, res_of(ms_to_ws_bus)); end
        cycle();
        es_to_ms_valid = 1'b0;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL store_wait got=%b exp=0", ms_to_ws_valid); end
        cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hFFFF_FFFF;
        #1;
        checks++; if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== {1'b0, 5'd2, 32'hA5A5_0004, 32'h0000_2004}) begin errors++; $display("FAIL store_ack got valid=%b bus=%h exp 1/%h", ms_to_ws_valid, ms_to_ws_bus, {1'b0, 5'd2, 32'hA5A5_0004, 32'h0000_2004}); end
        cycle();
        data_sram_data_ok = 1'b0;
        #1;
        checks++; if (in_ms_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", in_ms_valid); end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load_byte(LD_B, 32'hFFFF_FF80);
        test_load_byte(LD_BU, 32'h0000_0080);
        test_hold();
        test_flush_wait();
        test_flush_with_ok();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
